// File: rtl/vram_pkg.sv
// Shared types for the vector-port VRAM responder: line/byte-enable types,
// the clear/ready state encoding and the byte-lane merge helper.
package vram_pkg;

    localparam int VRAM_ADDR_W = 14;
    localparam int VRAM_DATA_W = 256;
    localparam int VRAM_BE_W   = 32;

    typedef enum logic {ST_CLEAR, ST_READY} vram_state_t;

    typedef logic [VRAM_DATA_W-1:0] vram_line_t;
    typedef logic [VRAM_BE_W-1:0]   vram_be_t;

    // Enabled lanes come from new_line, all others keep old_line.
    function automatic vram_line_t byte_merge(input vram_line_t old_line,
                                              input vram_line_t new_line,
                                              input vram_be_t   be);
        vram_line_t r;
        r = old_line;
        for (int i = 0; i < VRAM_BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = new_line[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/vram_clear_seq.sv
// Post-reset clear sequencer: walks every line once writing zero, then parks
// in READY until the next reset. The current state is exported for debug.
module vram_clear_seq
    import vram_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int IDX_W          = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic             clr_we,
    output logic [IDX_W-1:0] clr_addr,
    output logic             init_done,
    output vram_state_t      state
);

    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(DEPTH - 1);

    vram_state_t      state_q, state_d;
    logic [IDX_W-1:0] clr_addr_q, clr_addr_d;
    logic             init_done_q, init_done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) state_d = ST_READY;
            end
            default: ;
        endcase
        // Registered so init_done rises together with the first READY cycle.
        init_done_d = (state_d == ST_READY);
    end

    assign clr_addr  = clr_addr_q;
    assign init_done = init_done_q;
    assign state     = state_q;

endmodule

// File: rtl/vram_port_responder.sv
// Memory-side responder for the 256-bit vector data port with byte-enabled
// writes and 1-cycle read latency. Optional access counters: VRAM_STATS_EN.
module vram_port_responder
    import vram_pkg::*;
#(
    parameter int ADDR_W         = VRAM_ADDR_W,
    parameter int DEPTH          = 2**ADDR_W,
    parameter int DATA_W         = VRAM_DATA_W,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rden,
    input  logic                wren,
    input  logic [ADDR_W-1:0]   ip_address,
    input  logic [DATA_W/8-1:0] byteena,
    input  logic [DATA_W-1:0]   writeData,
    output logic [DATA_W-1:0]   readData,
    output logic                init_done
`ifdef VRAM_STATS_EN
    ,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

    // Request protocol: rden/wren are one-cycle strobes sampled at posedge with
    // no ready/backpressure; in READY every request is taken the cycle it appears.

    vram_state_t       st;
    logic              clr_we;
    logic [IDX_W-1:0]  clr_addr;

    vram_clear_seq #(
        .DEPTH         (DEPTH),
        .IDX_W         (IDX_W),
        .CLEAR_ON_RESET(CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .init_done(init_done),
        .state    (st)
    );

    logic [DATA_W-1:0] mem [DEPTH];

    logic              ready;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              acc_rd, acc_wr;
    logic [DATA_W-1:0] merged;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] read_data_q, read_data_d;

    always_comb begin
        ready    = (st == ST_READY);
        in_range = ({1'b0, ip_address} < DEPTH_LIM);
        idx      = ip_address[IDX_W-1:0];
        acc_rd   = ready && rden && in_range;
        acc_wr   = ready && wren && in_range;
        // Single address port: a same-cycle read sees the write merged in.
        merged   = byte_merge(mem[idx], writeData, wren ? byteena : '0);

        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = merged;
        if (!reset) begin
            if (clr_we) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr;
                mem_wdata = '0;
            end else if (acc_wr) begin
                mem_we = 1'b1;
            end
        end

        read_data_d = read_data_q;
        if (ready && rden) read_data_d = in_range ? merged : '0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) read_data_q <= '0;
        else       read_data_q <= read_data_d;
    end

    assign readData = read_data_q;

`ifdef VRAM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (acc_rd && (rd_count_q != 32'hFFFF_FFFF)) rd_count_d = rd_count_q + 32'd1;
        if (acc_wr && (wr_count_q != 32'hFFFF_FFFF)) wr_count_d = wr_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_vram_port_responder.sv
// Bench for vram_port_responder (DEPTH=16): directed + random traffic checked
// by a scoreboard fed from a line-array reference model.
module tb_vram_port_responder;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 256;
    localparam int BE_W   = 32;

    logic              clk;
    logic              reset;
    logic              rden;
    logic              wren;
    logic [ADDR_W-1:0] ip_address;
    logic [BE_W-1:0]   byteena;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] readData;
    logic              init_done;
`ifdef VRAM_STATS_EN
    logic [31:0]       rd_count;
    logic [31:0]       wr_count;
`endif

    vram_port_responder #(
        .ADDR_W        (ADDR_W),
        .DEPTH         (DEPTH),
        .DATA_W        (DATA_W),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rden      (rden),
        .wren      (wren),
        .ip_address(ip_address),
        .byteena   (byteena),
        .writeData (writeData),
        .readData  (readData),
        .init_done (init_done)
`ifdef VRAM_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mem_m[DEPTH];
    logic [DATA_W-1:0] last_rd_m;
    bit                ready_m;
    int unsigned       rd_m, wr_m;
    int                n_cmp, n_err;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: array of lines updated per byte lane, reads after writes.
    task automatic do_op(input bit rd, input bit wr, input int addr,
                         input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        @(negedge clk);
        rden       = rd;
        wren       = wr;
        ip_address = ADDR_W'(addr);
        byteena    = be;
        writeData  = d;
        if (ready_m) begin
            if (addr < DEPTH) begin
                if (wr) begin
                    for (int i = 0; i < BE_W; i++)
                        if (be[i]) mem_m[addr][8*i +: 8] = d[8*i +: 8];
                    wr_m++;
                end
                if (rd) begin
                    last_rd_m = mem_m[addr];
                    rd_m++;
                end
            end else if (rd) begin
                last_rd_m = '0;
            end
        end
        if (rd) exp_q.push_back(last_rd_m);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rden = 1'b0;
            wren = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic start_reset();
        @(negedge clk);
        reset   = 1'b1;
        rden    = 1'b0;
        wren    = 1'b0;
        ready_m = 1'b0;
        last_rd_m = '0;
        rd_m    = 0;
        wr_m    = 0;
        @(posedge clk);
        #1;
        check("init_done_in_reset", DATA_W'(init_done), '0);
        check("readData_in_reset", readData, '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_clear();
        for (int c = 1; c <= DEPTH; c++) begin
            @(posedge clk);
            #1;
            check("init_done_timing", DATA_W'(init_done), DATA_W'(c == DEPTH));
        end
        ready_m = 1'b1;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    endtask

    // scoreboard monitor: one pop per accepted rden, checked a cycle later
    initial begin
        bit fire;
        forever begin
            @(posedge clk);
            fire = (rden === 1'b1) && (reset === 1'b0);
            @(negedge clk);
            if (fire) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL readData_unexpected: got %h expected no pending read", readData);
                end else begin
                    check("readData", readData, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] d;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        rden = 1'b0;
        wren = 1'b0;
        ip_address = '0;
        byteena = '0;
        writeData = '0;

        // 1: clear timing and all lines zero
        start_reset();
        wait_clear();
        for (int a = 0; a < DEPTH; a++) do_op(1, 0, a, '0, '0);

        // 2: partial byte write then read
        do_op(0, 1, 3, 32'h0000_000F, {32{8'hAA}});
        do_op(1, 0, 3, '0, '0);

        // 3: split pair, back-to-back reads
        do_op(0, 1, 5, 32'hFFFF_0000, {{32{4'hA}}, 128'h0});
        do_op(0, 1, 6, 32'h0000_FFFF, {128'h0, {32{4'hB}}});
        do_op(1, 0, 5, '0, '0);
        do_op(1, 0, 6, '0, '0);

        // 4: same-cycle read and write, write-first merge
        do_op(0, 1, 7, '1, {32{8'h11}});
        do_op(1, 1, 7, 32'h0000_0001, {{31{8'h00}}, 8'h99});
        do_op(1, 0, 7, '0, '0);

        // byteena=0 write is a no-op; out-of-range access dropped / reads 0
        do_op(0, 1, 7, '0, {32{8'h55}});
        do_op(1, 1, 20, '1, {32{8'hEE}});
        do_op(1, 0, 20, '0, '0);
        do_op(1, 0, 7, '0, '0);
        do_op(1, 0, 4, '0, '0);

        // readData holds when rden is low
        drain();
        idle(3);
        #1;
        check("readData_hold", readData, last_rd_m);

        // 5: reset mid-clear restarts the sweep; earlier data is wiped
        do_op(0, 1, 2, '1, {32{8'h5A}});
        do_op(1, 0, 2, '0, '0);
        drain();
        start_reset();
        do_op(0, 1, 2, '1, {32{8'h77}});
        do_op(1, 0, 2, '0, '0);
        idle(5);
        start_reset();
        wait_clear();
        do_op(1, 0, 2, '0, '0);

        // random traffic including out-of-range addresses
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: be = '1;
                1: be = '0;
                2: be = $urandom();
                default: be = BE_W'(1) << $urandom_range(0, BE_W - 1);
            endcase
            for (int k = 0; k < DATA_W / 32; k++) d[32*k +: 32] = $urandom();
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, DEPTH + 1), be, d);
        end
        drain();

`ifdef VRAM_STATS_EN
        @(negedge clk);
        check("rd_count_random", DATA_W'(rd_count), DATA_W'(rd_m));
        check("wr_count_random", DATA_W'(wr_count), DATA_W'(wr_m));
        // 6: counters from a fresh reset
        start_reset();
        check("rd_count_reset", DATA_W'(rd_count), '0);
        wait_clear();
        do_op(1, 0, 1, '0, '0);
        do_op(1, 0, 2, '0, '0);
        do_op(1, 0, 3, '0, '0);
        do_op(0, 1, 4, '1, {32{8'h01}});
        do_op(0, 1, 5, '0, '0);
        do_op(1, 1, 6, 32'h3, {32{8'h02}});
        do_op(1, 1, 20, '1, {32{8'h03}});
        idle(1);
        @(negedge clk);
        check("rd_count", DATA_W'(rd_count), DATA_W'(32'd4));
        check("wr_count", DATA_W'(wr_count), DATA_W'(32'd3));
        check("rd_count_model", DATA_W'(rd_count), DATA_W'(rd_m));
        check("wr_count_model", DATA_W'(wr_count), DATA_W'(wr_m));
`endif

        drain();
        idle(2);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL exp_q_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
